// File: rtl/bcd_updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared BCD definitions for the up/down decade counter and its digit slices.
//   bcd_digit_t   : one 4-bit BCD decade
//   BCD_MAX       : largest legal decade value (9)
//   BCD_ZERO      : decade value zero
//   is_valid_bcd  : 1 when a nibble is a legal BCD digit (0..9)
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    function automatic logic is_valid_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter_if
// Control/status bundle of the BCD up/down counter.
//   master : drives clr, load, load_val, en, up; observes count, tc, wrap, load_err
//   slave  : the counter side (inverse directions)
// Parameter NUM_DIGITS sets the width of load_val/count (4 bits per decade).
// -----------------------------------------------------------------------------
interface bcd_updown_counter_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    clr;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic                    en;
    logic                    up;
    logic [4*NUM_DIGITS-1:0] count;
    logic                    tc;
    logic                    wrap;
    logic                    load_err;

    modport master (
        output clr, load, load_val, en, up,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/bcd_updown_counter_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD decade of the cascaded up/down counter.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset (q -> 0)
//   clr       : synchronous clear (highest priority)
//   load      : synchronous load of load_d (digits above 9 load as 9)
//   load_d    : load value for this decade
//   step_in   : advance this decade by one on the next edge
//   up        : 1 = increment, 0 = decrement
//   q         : registered decade value
//   step_out  : carry (up) / borrow (down) into the next decade
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t load_d,
    input  logic       step_in,
    input  logic       up,
    output bcd_digit_t q,
    output logic       step_out
);

    bcd_digit_t q_reg;
    bcd_digit_t q_next;

    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = BCD_ZERO;
        end else if (load) begin
            q_next = is_valid_bcd(load_d) ? load_d : BCD_MAX;
        end else if (step_in) begin
            if (up) begin
                q_next = (q_reg >= BCD_MAX) ? BCD_ZERO : q_reg + 4'd1;
            end else begin
                q_next = (q_reg == BCD_ZERO) ? BCD_MAX : q_reg - 4'd1;
            end
        end
    end

    // The next decade moves only when this one rolls over in the same edge.
    assign step_out = step_in & (up ? (q_reg == BCD_MAX) : (q_reg == BCD_ZERO));
    assign q        = q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= BCD_ZERO;
        end else begin
            q_reg <= q_next;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
// Cascaded BCD up/down counter of NUM_DIGITS decades (1..8).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (count, wrap, load_err -> 0)
//   bus  : bcd_updown_counter_if.slave
//          clr > load > en priority; up selects direction;
//          count (registered), tc (combinational terminal count),
//          wrap (registered roll-over pulse), load_err (registered pulse
//          when a loaded digit was above 9 and got clamped to 9)
// Build option:
//   BCD_CNT_SAT_EN : when defined the count saturates at all-9 (up) or
//                    zero (down) instead of wrapping; wrap stays 0.
// -----------------------------------------------------------------------------
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_updown_counter_if.slave  bus
);

    bcd_digit_t              digit_q [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] count_flat;
    logic                    all_max;
    logic                    all_zero;
    logic                    any_bad;
    logic                    at_limit;
    logic                    step_first;
    logic                    top_step;
    logic                    wrap_reg;
    logic                    wrap_next;
    logic                    load_err_reg;
    logic                    load_err_next;

    always_comb begin
        count_flat = '0;
        all_max    = 1'b1;
        all_zero   = 1'b1;
        any_bad    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            count_flat[4*i +: 4] = digit_q[i];
            all_max  = all_max  & (digit_q[i] == BCD_MAX);
            all_zero = all_zero & (digit_q[i] == BCD_ZERO);
            any_bad  = any_bad  | ~is_valid_bcd(bus.load_val[4*i +: 4]);
        end
    end

    assign at_limit = bus.up ? all_max : all_zero;

`ifdef BCD_CNT_SAT_EN
    // Suppress the step at the limit so no decade moves and no carry escapes.
    assign step_first = bus.en & ~at_limit;
`else
    assign step_first = bus.en;
`endif

    // Each link of the carry/borrow chain is a separate net per decade so the
    // ripple path does not fold back onto a single vector.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic step_in_w;
        logic step_out_w;

        if (gi == 0) begin : g_first
            assign step_in_w = step_first;
        end else begin : g_rest
            assign step_in_w = g_digit[gi-1].step_out_w;
        end

        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .clr      (bus.clr),
            .load     (bus.load),
            .load_d   (bus.load_val[4*gi +: 4]),
            .step_in  (step_in_w),
            .up       (bus.up),
            .q        (digit_q[gi]),
            .step_out (step_out_w)
        );
    end

    // A carry out of the top decade is exactly a full-range roll-over.
    assign top_step      = g_digit[NUM_DIGITS-1].step_out_w;
    assign wrap_next     = top_step & ~bus.clr & ~bus.load;
    assign load_err_next = bus.load & ~bus.clr & any_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            wrap_reg     <= wrap_next;
            load_err_reg <= load_err_next;
        end
    end

    assign bus.count    = count_flat;
    assign bus.tc       = bus.en & at_limit;
    assign bus.wrap     = wrap_reg;
    assign bus.load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
// Directed vectors for a 4-decade and a 1-decade counter. The drivers push the
// expected post-edge state into per-DUT queues; a monitor pops and compares one
// entry after every rising edge while out of reset. Expectations follow the
// BCD_CNT_SAT_EN build option when it is defined.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

`ifdef BCD_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [15:0] cnt;
        logic        wrp;
        logic        err;
        string       tag;
    } exp4_t;

    typedef struct {
        logic [3:0] cnt;
        logic       wrp;
        logic       err;
        string      tag;
    } exp1_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    exp4_t q4[$];
    exp1_t q1[$];
    exp4_t m4;
    exp1_t m1;

    always #5 clk = ~clk;

    bcd_updown_counter_if #(.NUM_DIGITS(4)) bus4 ();
    bcd_updown_counter_if #(.NUM_DIGITS(1)) bus1 ();

    bcd_updown_counter #(.NUM_DIGITS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    bcd_updown_counter #(.NUM_DIGITS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic digits_ok(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Monitor: one queued expectation per edge while out of reset.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (q4.size() > 0) begin
                m4 = q4.pop_front();
                $display("txn dut4 %s count=%h wrap=%b load_err=%b", m4.tag,
                         bus4.count, bus4.wrap, bus4.load_err);
                chk({m4.tag, " count"}, 32'(bus4.count), 32'(m4.cnt));
                chk({m4.tag, " wrap"}, 32'(bus4.wrap), 32'(m4.wrp));
                chk({m4.tag, " load_err"}, 32'(bus4.load_err), 32'(m4.err));
                chk({m4.tag, " bcd_digits"}, 32'(digits_ok(bus4.count)), 32'd1);
            end
            if (q1.size() > 0) begin
                m1 = q1.pop_front();
                $display("txn dut1 %s count=%h wrap=%b load_err=%b", m1.tag,
                         bus1.count, bus1.wrap, bus1.load_err);
                chk({m1.tag, " count"}, 32'(bus1.count), 32'(m1.cnt));
                chk({m1.tag, " wrap"}, 32'(bus1.wrap), 32'(m1.wrp));
                chk({m1.tag, " load_err"}, 32'(bus1.load_err), 32'(m1.err));
            end
        end
    end

    task automatic drive4(input logic c, input logic l, input logic [15:0] lv,
                          input logic e, input logic u,
                          input logic [15:0] ec, input logic ew, input logic ee,
                          input logic etc_v, input string tag);
        exp4_t x;
        @(negedge clk);
        bus4.clr = c; bus4.load = l; bus4.load_val = lv; bus4.en = e; bus4.up = u;
        #1;
        chk({tag, " tc"}, 32'(bus4.tc), 32'(etc_v));
        x.cnt = ec; x.wrp = ew; x.err = ee; x.tag = tag;
        q4.push_back(x);
        @(posedge clk);
    endtask

    task automatic drive1(input logic e, input logic u,
                          input logic [3:0] ec, input logic ew,
                          input logic etc_v, input string tag);
        exp1_t x;
        @(negedge clk);
        bus1.clr = 1'b0; bus1.load = 1'b0; bus1.load_val = 4'h0; bus1.en = e; bus1.up = u;
        #1;
        chk({tag, " tc"}, 32'(bus1.tc), 32'(etc_v));
        x.cnt = ec; x.wrp = ew; x.err = 1'b0; x.tag = tag;
        q1.push_back(x);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] up_tab [12] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                 16'h0005, 16'h0006, 16'h0007, 16'h0008,
                                 16'h0009, 16'h0010, 16'h0011, 16'h0012};

    initial begin
        bus4.clr = 1'b0; bus4.load = 1'b0; bus4.load_val = '0; bus4.en = 1'b1; bus4.up = 1'b0;
        bus1.clr = 1'b0; bus1.load = 1'b0; bus1.load_val = '0; bus1.en = 1'b0; bus1.up = 1'b0;

        // Reset state; tc follows its equation even while held in reset.
        #2;
        chk("reset count", 32'(bus4.count), 32'h0);
        chk("reset wrap", 32'(bus4.wrap), 32'h0);
        chk("reset load_err", 32'(bus4.load_err), 32'h0);
        chk("reset tc down", 32'(bus4.tc), 32'h1);
        bus4.up = 1'b1;
        #1;
        chk("reset tc up", 32'(bus4.tc), 32'h0);
        @(posedge clk); #1;
        chk("reset holds on edge", 32'(bus4.count), 32'h0);
        @(negedge clk);
        bus4.en = 1'b0;
        rst = 1'b1;

        // Count up 12 times from zero.
        for (int i = 0; i < 12; i++) begin
            drive4(0, 0, 16'h0, 1, 1, up_tab[i], 0, 0, 0, "count_up");
        end
        drive4(0, 0, 16'h0, 0, 1, 16'h0012, 0, 0, 0, "idle");

        // Up roll-over.
        drive4(0, 1, 16'h9998, 0, 1, 16'h9998, 0, 0, 0, "load9998");
        drive4(0, 0, 16'h0, 1, 1, 16'h9999, 0, 0, 0, "up9999");
        drive4(0, 0, 16'h0, 1, 1, SAT ? 16'h9999 : 16'h0000, !SAT, 0, 1, "wrap_up");
        drive4(0, 0, 16'h0, 0, 1, SAT ? 16'h9999 : 16'h0000, 0, 0, 0, "after_wrap_up");

        // Down roll-over.
        drive4(0, 1, 16'h0001, 0, 0, 16'h0001, 0, 0, 0, "load0001");
        drive4(0, 0, 16'h0, 1, 0, 16'h0000, 0, 0, 0, "down0000");
        drive4(0, 0, 16'h0, 1, 0, SAT ? 16'h0000 : 16'h9999, !SAT, 0, 1, "wrap_down");

        // Borrow chain and direction change without a dead cycle.
        drive4(0, 1, 16'h1000, 0, 0, 16'h1000, 0, 0, 0, "load1000");
        drive4(0, 0, 16'h0, 1, 0, 16'h0999, 0, 0, 0, "borrow");
        drive4(0, 0, 16'h0, 1, 1, 16'h1000, 0, 0, 0, "dir_flip");

        // Invalid load digits clamp to 9 with a one-cycle error pulse.
        drive4(0, 1, 16'h12F4, 0, 0, 16'h1294, 0, 1, 0, "load_bad");
        drive4(0, 0, 16'h0, 0, 0, 16'h1294, 0, 0, 0, "err_clear");
        drive4(0, 1, 16'hABCD, 0, 0, 16'h9999, 0, 1, 0, "load_abcd");

        // Priority: clr beats load and en; tc ignores clr/load.
        drive4(1, 1, 16'h5555, 1, 1, 16'h0000, 0, 0, 1, "clr_all");
        drive4(1, 1, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0, "clr_vs_bad");
        drive4(0, 1, 16'h4321, 1, 1, 16'h4321, 0, 0, 0, "load_vs_en");
        drive4(0, 0, 16'h0, 1, 1, 16'h4322, 0, 0, 0, "up_after_load");
        drive4(0, 0, 16'h0, 1, 1, 16'h4323, 0, 0, 0, "up_again");

        // Asynchronous reset mid-cycle while counting.
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst count", 32'(bus4.count), 32'h0);
        chk("async_rst wrap", 32'(bus4.wrap), 32'h0);
        @(posedge clk); #1;
        chk("async_rst held", 32'(bus4.count), 32'h0);
        @(negedge clk);
        bus4.en = 1'b0;
        rst = 1'b1;
        drive4(0, 0, 16'h0, 1, 1, 16'h0001, 0, 0, 0, "first_after_rst");
        drive4(0, 0, 16'h0, 0, 1, 16'h0001, 0, 0, 0, "idle_end");

        // Single-decade counter: 0..9 then roll-over.
        for (int i = 1; i <= 9; i++) begin
            drive1(1, 1, 4'(i), 0, 0, "d1_up");
        end
        drive1(1, 1, SAT ? 4'h9 : 4'h0, !SAT, 1, "d1_wrap");
        drive1(0, 1, SAT ? 4'h9 : 4'h0, 0, 0, "d1_idle");

        repeat (2) @(posedge clk);
        #2;
        chk("queues_drained", 32'(q4.size() + q1.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of cascaded BCD decades (legal range 1..8).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-low; clock clk.
REQ-004 clr  input  1  synchronous clear to zero.
REQ-005 load  input  1  synchronous parallel load.
REQ-006 load_val  input  4*NUM_DIGITS  load value; digit i occupies bits [4i+3:4i].
REQ-007 en  input  1  count enable.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 count  output  4*NUM_DIGITS  registered BCD count; digit 0 is least significant.
REQ-010 tc  output  1  combinational terminal count.
REQ-011 wrap  output  1  registered one-cycle roll-over pulse.
REQ-012 load_err  output  1  registered one-cycle pulse for an invalid load digit.

Function
REQ-013 Per-edge priority SHALL be clr > load > en; with none of them asserted, count, wrap and load_err hold or return to 0 as defined below.
REQ-014 clr SHALL set count to 0 on the next edge, and wrap=0, load_err=0 for that cycle.
REQ-015 load SHALL register load_val on the next edge; any digit >9 SHALL be loaded as 9 and SHALL raise load_err=1 for one cycle.
REQ-016 en with up=1 SHALL increment by one decimal unit; each digit steps 0..9 then 9->0 with carry into the next digit.
REQ-017 en with up=0 SHALL decrement by one decimal unit; each digit steps 9..0 then 0->9 with borrow into the next digit.
REQ-018 A digit SHALL change only when en=1 and all lower digits are 9 (up) or 0 (down); latency from en to count is 1 cycle.
REQ-019 tc SHALL be en & (up ? count==all-9 : count==0), evaluated combinationally and independent of clr/load.
REQ-020 Without BCD_CNT_SAT_EN, the count SHALL wrap all-9 -> 0 (up) and 0 -> all-9 (down), with wrap=1 in the cycle after the wrapping edge.
REQ-021 A change of up while en=1 SHALL take effect on the same edge; no dead cycle.
REQ-022 count SHALL never hold a digit >9 once out of reset.

Reset
REQ-023 rst=0 SHALL asynchronously force count=0, wrap=0, load_err=0; tc follows its equation.
REQ-024 Deasserting rst SHALL allow counting from the first subsequent rising edge; reset mid-count discards state.

Configuration
REQ-025 With `BCD_CNT_SAT_EN defined, the counter SHALL saturate: it holds at all-9 when counting up and at 0 when counting down, wrap SHALL stay 0, and tc is unchanged.
REQ-026 Without BCD_CNT_SAT_EN, wrap-around SHALL follow REQ-020.

Structure
REQ-027 A shared package bcd_pkg SHALL hold BCD_MAX (4'd9), BCD_ZERO, the digit typedef bcd_digit_t (4-bit), and the function is_valid_bcd.
REQ-028 A sub-module bcd_digit SHALL implement one decade with its own D registers and inputs clr, load, load_d, step_in, up, and outputs q and step_out; the top SHALL generate NUM_DIGITS instances chained via step_out->step_in.

Verification (NUM_DIGITS=4 unless stated)
REQ-029 Reset pulse, then en=1, up=1 for 12 cycles -> count 0x0000..0x0012; no hex digit A-F ever appears.
REQ-030 load 0x9998, then en=1, up=1 -> 0x9999 with tc=1, then 0x0000 with wrap=1 for one cycle; with BCD_CNT_SAT_EN the count holds 0x9999 and wrap=0.
REQ-031 load 0x0001, then en=1, up=0 -> 0x0000, then 0x9999 with wrap=1; the borrow chain 0x1000 -> 0x0999 is checked.
REQ-032 load 0x12F4 -> count 0x1294, load_err=1 for exactly one cycle.
REQ-033 clr, load and en asserted on the same edge -> count 0x0000; load alone with en -> load_val wins.
REQ-034 rst asserted asynchronously mid-cycle during counting -> count is 0 immediately; NUM_DIGITS=1 run up 9 -> 0 with wrap=1.
